// File: rtl/fetch_pc_gen.sv
// F1 fetch-PC generator for a dual-issue front end: holds the pair PC and
// predicts taken branches for both slots from a direct-mapped BTB with 2-bit counters.
module fetch_pc_gen #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        frontend_we_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_tgt_i,
  output logic [31:0] pc_o,
  output logic        pred_0_o,
  output logic        pred_1_o,
  output logic [31:0] pred_tgt_0_o,
  output logic [31:0] pred_tgt_1_o,
  output logic        stall_o
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [IDX-1:0] CLR_LAST = IDX'(BTB_ENTRIES - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX-1:0]    clr_q, clr_d;
  logic [31:0]       pc_q, pc_d;

  logic              valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0]  tag_q   [BTB_ENTRIES];
  logic [31:0]       tgt_q   [BTB_ENTRIES];
  logic [1:0]        ctr_q   [BTB_ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic              run;
  logic [31:0]       pc1;
  logic [IDX-1:0]    idx0, idx1, uidx;
  logic [TAG_W-1:0]  tag0, tag1, utag;
  logic              hit0, hit1, uhit, upd_en;
  logic [3:0]        lo_bits_unused;

  assign run  = (state_q == RUN);
  assign pc1  = pc_q + 32'd4;
  assign idx0 = pc_q[IDX+1:2];
  assign tag0 = pc_q[31:IDX+2];
  assign idx1 = pc1[IDX+1:2];
  assign tag1 = pc1[31:IDX+2];
  assign uidx = update_pc_i[IDX+1:2];
  assign utag = update_pc_i[31:IDX+2];
  assign lo_bits_unused = {pc1[1:0], update_pc_i[1:0]};

  // Lookup stage: two combinational read ports, masked while the BTB is being cleared
  assign hit0 = run && valid_q[idx0] && (tag_q[idx0] == tag0);
  assign hit1 = run && valid_q[idx1] && (tag_q[idx1] == tag1);

  assign pred_0_o     = hit0 && ctr_q[idx0][1];
  assign pred_1_o     = hit1 && ctr_q[idx1][1] && !pred_0_o;
  assign pred_tgt_0_o = hit0 ? tgt_q[idx0] : 32'd0;
  assign pred_tgt_1_o = hit1 ? tgt_q[idx1] : 32'd0;
  assign pc_o         = pc_q;
  assign stall_o      = !run;

  assign uhit   = valid_q[uidx] && (tag_q[uidx] == utag);
  assign upd_en = run && update_valid_i && !reset_i;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    pc_d    = pc_q;
    case (state_q)
      INIT: begin
        pc_d  = RESET_PC;
        clr_d = clr_q + 1'b1;
        if (clr_q == CLR_LAST) state_d = RUN;
      end
      RUN: begin
        if (redirect_i)         pc_d = redirect_pc_i;
        else if (frontend_we_i) pc_d = pred_0_o ? pred_tgt_0_o :
                                       pred_1_o ? pred_tgt_1_o : pc_q + 32'd8;
      end
      default: state_d = INIT;
    endcase
  end

  // Control state: FSM, clear counter, fetch PC
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= INIT;
      clr_q   <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      pc_q    <= pc_d;
    end
  end

  // BTB write port: one valid bit cleared per INIT cycle, resolved-branch update in RUN
  always_ff @(posedge clock_i) begin
    if (!run) begin
      valid_q[clr_q] <= 1'b0;
    end else if (upd_en) begin
      if (uhit) begin
        if (update_taken_i) begin
          ctr_q[uidx] <= sat_inc(ctr_q[uidx]);
          tgt_q[uidx] <= update_tgt_i;
        end else begin
          ctr_q[uidx] <= sat_dec(ctr_q[uidx]);
        end
      end else if (update_taken_i) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        tgt_q[uidx]   <= update_tgt_i;
        ctr_q[uidx]   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scenario bench for fetch_pc_gen: expected outputs are queued as each cycle is driven
// and compared after the clock edge that should produce them.
module tb_fetch_pc_gen;

  logic        clock_i = 1'b0;
  logic        reset_i, frontend_we_i, redirect_i, update_valid_i, update_taken_i;
  logic [31:0] redirect_pc_i, update_pc_i, update_tgt_i;
  logic [31:0] pc_o, pred_tgt_0_o, pred_tgt_1_o;
  logic        pred_0_o, pred_1_o, stall_o;

  fetch_pc_gen #(.BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .frontend_we_i(frontend_we_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .update_tgt_i(update_tgt_i),
    .pc_o(pc_o), .pred_0_o(pred_0_o), .pred_1_o(pred_1_o),
    .pred_tgt_0_o(pred_tgt_0_o), .pred_tgt_1_o(pred_tgt_1_o), .stall_o(stall_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic        stall;
    logic [31:0] pc;
    logic        p0;
    logic [31:0] t0;
    logic        p1;
    logic [31:0] t1;
  } obs_t;

  typedef struct packed {
    logic        rst, we, rd;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    obs_t        exp;
  } step_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t E(logic stall, logic [31:0] pc, logic p0, logic [31:0] t0,
                             logic p1, logic [31:0] t1);
    obs_t o;
    o.stall = stall; o.pc = pc; o.p0 = p0; o.t0 = t0; o.p1 = p1; o.t1 = t1;
    return o;
  endfunction

  function automatic step_t mk(logic rst, logic we, logic rd, logic [31:0] rpc,
                               logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                               obs_t exp);
    step_t s;
    s.rst = rst; s.we = we; s.rd = rd; s.rpc = rpc;
    s.uv = uv; s.upc = upc; s.ut = ut; s.utgt = utgt; s.exp = exp;
    return s;
  endfunction

  function automatic obs_t sample();
    return E(stall_o, pc_o, pred_0_o, pred_tgt_0_o, pred_1_o, pred_tgt_1_o);
  endfunction

  function automatic string fmt(obs_t g, obs_t x);
    return $sformatf("got stall=%b pc=%h p0=%b t0=%h p1=%b t1=%h, expected stall=%b pc=%h p0=%b t0=%h p1=%b t1=%h",
                     g.stall, g.pc, g.p0, g.t0, g.p1, g.t1, x.stall, x.pc, x.p0, x.t0, x.p1, x.t1);
  endfunction

  // Drive one cycle of stimulus, queue the outputs it should produce, then pass the edge.
  task automatic apply(input step_t s);
    reset_i        = s.rst;
    frontend_we_i  = s.we;
    redirect_i     = s.rd;
    redirect_pc_i  = s.rpc;
    update_valid_i = s.uv;
    update_pc_i    = s.upc;
    update_taken_i = s.ut;
    update_tgt_i   = s.utgt;
    exp_q.push_back(s.exp);
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    obs_t  got, exp;
    s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, E(1, 32'h0, 0, 0, 0, 0)));
    for (int i = 0; i < 15; i++)
      s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(1, 32'h0, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h00, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h08, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h10, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h18, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: %s", i, fmt(got, exp));
      end
    end
  endtask

  task automatic test_hold();
    step_t s[$];
    obs_t  got, exp;
    for (int i = 0; i < 3; i++)
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, E(0, 32'h18, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h20, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hold[%0d]: %s", i, fmt(got, exp));
      end
    end
  endtask

  task automatic test_pred_slot0();
    step_t s[$];
    obs_t  got, exp;
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 32'h100, E(0, 32'h20, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 32'h10, 0, 0, 0, 0, E(0, 32'h10, 1, 32'h100, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h100, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pred_slot0[%0d]: %s", i, fmt(got, exp));
      end
    end
  endtask

  task automatic test_pred_slot1();
    step_t s[$];
    obs_t  got, exp;
    s.push_back(mk(0, 0, 0, 0, 1, 32'h34, 1, 32'h200, E(0, 32'h100, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 32'h30, 0, 0, 0, 0, E(0, 32'h30, 0, 0, 1, 32'h200)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h200, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 32'h30, 1, 32'h30, 1, 32'h80, E(0, 32'h30, 1, 32'h80, 0, 32'h200)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h80, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pred_slot1[%0d]: %s", i, fmt(got, exp));
      end
    end
  endtask

  task automatic test_redirect();
    step_t s[$];
    obs_t  got, exp;
    s.push_back(mk(0, 0, 1, 32'h10, 0, 0, 0, 0, E(0, 32'h10, 1, 32'h100, 0, 0)));
    s.push_back(mk(0, 0, 1, 32'h40, 0, 0, 0, 0, E(0, 32'h40, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 32'h40, 1, 32'h44, 1, 32'h300, E(0, 32'h40, 0, 0, 1, 32'h300)));
    s.push_back(mk(0, 0, 1, 32'h10, 0, 0, 0, 0, E(0, 32'h10, 1, 32'h100, 0, 0)));
    s.push_back(mk(0, 1, 1, 32'h48, 0, 0, 0, 0, E(0, 32'h48, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL redirect[%0d]: %s", i, fmt(got, exp));
      end
    end
  endtask

  task automatic test_counter_and_reinit();
    step_t s[$];
    obs_t  got, exp;
    s.push_back(mk(0, 0, 1, 32'h10, 0, 0, 0, 0, E(0, 32'h10, 1, 32'h100, 0, 0)));
    for (int i = 0; i < 3; i++)   // 10 -> 01 -> 00 -> 00
      s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, E(0, 32'h10, 0, 32'h100, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 32'h100, E(0, 32'h10, 0, 32'h100, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 32'h100, E(0, 32'h10, 1, 32'h100, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 32'h100, E(0, 32'h10, 1, 32'h100, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1, 32'h120, E(0, 32'h10, 1, 32'h120, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, E(0, 32'h10, 1, 32'h120, 0, 0)));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, E(0, 32'h10, 0, 32'h120, 0, 0)));
    // Mid-stream reset; redirects and updates during the clear must be ignored
    s.push_back(mk(1, 1, 0, 0, 1, 32'h10, 1, 32'h100, E(1, 32'h0, 0, 0, 0, 0)));
    for (int i = 0; i < 15; i++)
      s.push_back(mk(0, 1, 1, 32'h40, 0, 0, 0, 0, E(1, 32'h0, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 1, 32'h40, 1, 32'h0, 1, 32'h500, E(0, 32'h0, 0, 0, 0, 0)));
    s.push_back(mk(0, 0, 1, 32'h10, 0, 0, 0, 0, E(0, 32'h10, 0, 0, 0, 0)));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, E(0, 32'h18, 0, 0, 0, 0)));
    foreach (s[i]) begin
      apply(s[i]);
      got = sample();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL counter_reinit[%0d]: %s", i, fmt(got, exp));
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; frontend_we_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    update_valid_i = 1'b0; update_pc_i = '0; update_taken_i = 1'b0; update_tgt_i = '0;
    test_reset();
    test_hold();
    test_pred_slot0();
    test_pred_slot1();
    test_redirect();
    test_counter_and_reinit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
